// File: rtl/vga_fb_arbiter_pkg.sv
// Shared definitions for the framebuffer arbiter.
//   FB_DW          framebuffer data width (32-bit words)
//   FB_AW_DEFAULT  default framebuffer word-address width (16K words)
//   grant_e        per-cycle RAM owner, used internally and for debug
package vga_fb_pkg;

  localparam int unsigned FB_DW         = 32;
  localparam int unsigned FB_AW_DEFAULT = 14;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_VGA,
    GNT_CPU
  } grant_e;

endpackage

// File: rtl/vga_fb_arbiter.sv
// Framebuffer RAM arbiter: shares one single-port, 1-cycle-read BRAM between
// the CPU Wishbone slave port and the VGA line-prefetch reader (core clock
// domain only). VGA has fixed priority. After MAX_VGA_RUN consecutive VGA
// grants with the CPU waiting, one CPU slot is forced.
//
// Optional build macro: VGA_FB_ARB_STATS_EN enables the CPU stall-cycle
// counter on o_cpu_stall_cnt. Without it, the output is tied to 0.
//
// Ports:
//   clk, rstn         core clock, asynchronous active-low reset
//   i_wb_*            Wishbone classic slave (byte address, word = adr[AW+1:2])
//   o_wb_rdt/o_wb_ack read data / ack, ack one cycle after grant
//   i_vga_req/addr    VGA read request (level, held until granted) and word address
//   o_vga_gnt         VGA request accepted this cycle
//   o_vga_rdata/rvalid VGA read data, valid one cycle after grant
//   o_ram_*           RAM enable, byte write enables, word address, write data
//   i_ram_rdata       RAM read data, valid the cycle after o_ram_en
//   i_stats_clr       synchronous clear of the stall counter
//   o_cpu_stall_cnt   cycles the CPU waited while pending (saturating)
module vga_fb_arbiter
  import vga_fb_pkg::*;
#(
  parameter int unsigned AW          = FB_AW_DEFAULT,
  parameter int unsigned MAX_VGA_RUN = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_wb_cyc,
  input  logic              i_wb_stb,
  input  logic              i_wb_we,
  input  logic [AW+1:0]     i_wb_adr,
  input  logic [FB_DW-1:0]  i_wb_dat,
  input  logic [3:0]        i_wb_sel,
  output logic [FB_DW-1:0]  o_wb_rdt,
  output logic              o_wb_ack,
  input  logic              i_vga_req,
  input  logic [AW-1:0]     i_vga_addr,
  output logic              o_vga_gnt,
  output logic [FB_DW-1:0]  o_vga_rdata,
  output logic              o_vga_rvalid,
  output logic              o_ram_en,
  output logic [3:0]        o_ram_we,
  output logic [AW-1:0]     o_ram_addr,
  output logic [FB_DW-1:0]  o_ram_wdata,
  input  logic [FB_DW-1:0]  i_ram_rdata,
  input  logic              i_stats_clr,
  output logic [31:0]       o_cpu_stall_cnt
);

  localparam logic [7:0] RUN_MAX = 8'(MAX_VGA_RUN);

  grant_e     grant;
  logic       cpu_pend;
  logic       gnt_cpu;
  logic       gnt_vga;
  logic       ack_q,    ack_d;
  logic       rvalid_q, rvalid_d;
  logic [7:0] run_q,    run_d;

  // The ~ack term keeps a CPU strobe still held in its ack cycle from being
  // granted a second time.
  assign cpu_pend = i_wb_cyc & i_wb_stb & ~ack_q;

  always_comb begin
    grant = GNT_NONE;
    if (cpu_pend && (!i_vga_req || run_q == RUN_MAX)) begin
      grant = GNT_CPU;
    end else if (i_vga_req) begin
      grant = GNT_VGA;
    end
  end

  assign gnt_cpu = (grant == GNT_CPU);
  assign gnt_vga = (grant == GNT_VGA);

  // Run length of VGA grants taken while the CPU waits. Any CPU grant or a
  // CPU that is no longer pending starts the count over.
  always_comb begin
    run_d = run_q;
    if (gnt_cpu || !cpu_pend) begin
      run_d = '0;
    end else if (gnt_vga && run_q != RUN_MAX) begin
      run_d = run_q + 8'd1;
    end
  end

  always_comb begin
    ack_d    = gnt_cpu;
    rvalid_d = gnt_vga;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ack_q    <= 1'b0;
      rvalid_q <= 1'b0;
      run_q    <= '0;
    end else begin
      ack_q    <= ack_d;
      rvalid_q <= rvalid_d;
      run_q    <= run_d;
    end
  end

  assign o_vga_gnt    = gnt_vga;
  assign o_wb_ack     = ack_q;
  assign o_vga_rvalid = rvalid_q;
  assign o_wb_rdt     = i_ram_rdata;
  assign o_vga_rdata  = i_ram_rdata;

  assign o_ram_en    = gnt_cpu | gnt_vga;
  assign o_ram_addr  = gnt_cpu ? i_wb_adr[AW+1:2] : i_vga_addr;
  assign o_ram_we    = (gnt_cpu && i_wb_we) ? i_wb_sel : '0;
  assign o_ram_wdata = i_wb_dat;

`ifdef VGA_FB_ARB_STATS_EN
  logic [31:0] stall_q, stall_d;

  // Clear takes precedence over a same-cycle increment.
  always_comb begin
    stall_d = stall_q;
    if (i_stats_clr) begin
      stall_d = '0;
    end else if (cpu_pend && !gnt_cpu && stall_q != '1) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign o_cpu_stall_cnt = stall_q;

  logic unused_adr_bits;
  assign unused_adr_bits = ^i_wb_adr[1:0];
`else
  assign o_cpu_stall_cnt = '0;

  logic unused_inputs;
  assign unused_inputs = ^{i_wb_adr[1:0], i_stats_clr};
`endif

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Self-checking bench for vga_fb_arbiter: directed stimulus, expected
// responses queued at issue time and checked by a separate monitor.
module tb_vga_fb_arbiter;
  import vga_fb_pkg::*;

  localparam int unsigned AW = 14;

  logic              clk = 1'b0;
  logic              rstn;
  logic              cyc, stb, wb_we;
  logic [AW+1:0]     wb_adr;
  logic [31:0]       wb_dat;
  logic [3:0]        wb_sel;
  logic [31:0]       wb_rdt;
  logic              wb_ack;
  logic              vga_req;
  logic [AW-1:0]     vga_addr;
  logic              vga_gnt;
  logic [31:0]       vga_rdata;
  logic              vga_rvalid;
  logic              ram_en;
  logic [3:0]        ram_we;
  logic [AW-1:0]     ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;
  logic              stats_clr;
  logic [31:0]       stall_cnt;

  vga_fb_arbiter #(.AW(AW), .MAX_VGA_RUN(8)) dut (
    .clk(clk), .rstn(rstn),
    .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(wb_we), .i_wb_adr(wb_adr),
    .i_wb_dat(wb_dat), .i_wb_sel(wb_sel), .o_wb_rdt(wb_rdt), .o_wb_ack(wb_ack),
    .i_vga_req(vga_req), .i_vga_addr(vga_addr), .o_vga_gnt(vga_gnt),
    .o_vga_rdata(vga_rdata), .o_vga_rvalid(vga_rvalid),
    .o_ram_en(ram_en), .o_ram_we(ram_we), .o_ram_addr(ram_addr),
    .o_ram_wdata(ram_wdata), .i_ram_rdata(ram_rdata),
    .i_stats_clr(stats_clr), .o_cpu_stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input int unsigned a);
    return 32'hC0DE_0000 | 32'(a);
  endfunction

  // Behavioural framebuffer: read-first, 1-cycle registered read.
  logic [31:0] mem [0:255];
  logic        preloaded = 1'b0;
  always @(posedge clk) begin
    if (!preloaded) begin
      for (int i = 0; i < 256; i++) mem[i] <= pat(i);
      preloaded <= 1'b1;
    end else if (ram_en) begin
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) mem[ram_addr[7:0]][b*8 +: 8] <= ram_wdata[b*8 +: 8];
      ram_rdata <= mem[ram_addr[7:0]];
    end
  end

  typedef struct packed {
    logic        is_read;
    logic [31:0] data;
  } cpu_exp_t;

  cpu_exp_t    cpu_q[$];
  logic [31:0] vga_q[$];
  int unsigned vectors     = 0;
  int unsigned miscompares = 0;
  logic        prev_cpu    = 1'b0;
  logic        prev_vga    = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a response.
  initial begin
    cpu_exp_t e;
    logic [31:0] ve;
    forever begin
      @(negedge clk);
      if (wb_ack) begin
        if (cpu_q.size() == 0) check("cpu_spurious_ack", 32'(wb_ack), 32'd0);
        else begin
          e = cpu_q.pop_front();
          check("cpu_ack_latency", 32'(prev_cpu), 32'd1);
          if (e.is_read) check("cpu_rdata", wb_rdt, e.data);
        end
      end
      if (vga_rvalid) begin
        if (vga_q.size() == 0) check("vga_spurious_rvalid", 32'(vga_rvalid), 32'd0);
        else begin
          ve = vga_q.pop_front();
          check("vga_rvalid_latency", 32'(prev_vga), 32'd1);
          check("vga_rdata", vga_rdata, ve);
        end
      end
      prev_cpu = ram_en & ~vga_gnt;
      prev_vga = vga_gnt;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_access(input logic we, input logic [AW+1:0] adr, input logic [31:0] dat,
                            input logic [3:0] sel, input logic [31:0] exp_rdt,
                            input logic chk_drive);
    bit got = 1'b0;
    cyc = 1'b1; stb = 1'b1; wb_we = we; wb_adr = adr; wb_dat = dat; wb_sel = sel;
    cpu_q.push_back('{is_read: ~we, data: exp_rdt});
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      if (chk_drive && n == 0) begin
        check("cpu_ram_en", 32'(ram_en), 32'd1);
        check("cpu_ram_addr", 32'(ram_addr), 32'(adr[AW+1:2]));
        check("cpu_ram_we", 32'(ram_we), we ? 32'(sel) : 32'd0);
        check("cpu_no_ack_in_N", 32'(wb_ack), 32'd0);
      end
      if (wb_ack) got = 1'b1;
      step();
    end
    check("cpu_ack_seen", 32'(got), 32'd1);
    cyc = 1'b0; stb = 1'b0; wb_we = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 20 && (cpu_q.size() != 0 || vga_q.size() != 0); n++) @(negedge clk);
    check("drain_cpu_q", 32'(cpu_q.size()), 32'd0);
    check("drain_vga_q", 32'(vga_q.size()), 32'd0);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned va;
    logic        cpu_slot;
    logic [31:0] exp_stall_blocked;
    logic [31:0] exp_stall_one;
`ifdef VGA_FB_ARB_STATS_EN
    exp_stall_blocked = 32'd24;
    exp_stall_one     = 32'd1;
`else
    exp_stall_blocked = 32'd0;
    exp_stall_one     = 32'd0;
`endif
    rstn = 1'b0; cyc = 1'b0; stb = 1'b0; wb_we = 1'b0; wb_adr = '0; wb_dat = '0;
    wb_sel = '0; vga_req = 1'b0; vga_addr = '0; stats_clr = 1'b0;
    step(); step();
    @(negedge clk);
    check("rst_wb_ack", 32'(wb_ack), 32'd0);
    check("rst_vga_rvalid", 32'(vga_rvalid), 32'd0);
    check("rst_stall_cnt", stall_cnt, 32'd0);
    check("idle_ram_en", 32'(ram_en), 32'd0);
    step();
    rstn = 1'b1;
    step();

    // VGA-only burst, addresses 0..15.
    for (int i = 0; i < 16; i++) begin
      vga_req = 1'b1; vga_addr = 14'(i);
      @(negedge clk);
      check("burst_vga_gnt", 32'(vga_gnt), 32'd1);
      if (i == 0) check("burst_rvalid_delay", 32'(vga_rvalid), 32'd0);
      vga_q.push_back(pat(i));
      step();
    end
    vga_req = 1'b0;
    drain();

    // CPU-only word write, read-back, then byte-lane merge.
    cpu_access(1'b1, 16'h0010, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b1);
    cpu_access(1'b0, 16'h0010, 32'h0, 4'hF, 32'hDEAD_BEEF, 1'b1);
    cpu_access(1'b1, 16'h0020, 32'h1122_3344, 4'hF, 32'h0, 1'b0);
    cpu_access(1'b1, 16'h0020, 32'h0000_AB00, 4'h2, 32'h0, 1'b1);
    cpu_access(1'b0, 16'h0020, 32'h0, 4'hF, 32'h1122_AB44, 1'b0);
    drain();

    // Contention: CPU re-strobes right after each ack, VGA requests every
    // cycle. Forced CPU slots land on cycles 8, 18 and 28.
    cyc = 1'b1; stb = 1'b1; wb_we = 1'b0; wb_adr = 16'd800; wb_sel = 4'hF;
    vga_req = 1'b1; va = 64;
    for (int c = 0; c < 30; c++) begin
      vga_addr = 14'(va);
      @(negedge clk);
      cpu_slot = (c == 8 || c == 18 || c == 28);
      check("cont_vga_gnt", 32'(vga_gnt), 32'(!cpu_slot));
      if (cpu_slot) begin
        check("cont_cpu_addr", 32'(ram_addr), 32'd200);
        cpu_q.push_back('{is_read: 1'b1, data: pat(200)});
      end else begin
        vga_q.push_back(pat(va));
        va++;
      end
      step();
    end
    cyc = 1'b0; stb = 1'b0; vga_req = 1'b0;
    @(negedge clk);
    check("stall_after_contention", stall_cnt, exp_stall_blocked);
    step();

    // Stats clear during a blocked cycle, then CPU withdraws before grant.
    cyc = 1'b1; stb = 1'b1; vga_req = 1'b1; vga_addr = 14'(va); stats_clr = 1'b1;
    @(negedge clk);
    check("blk_vga_gnt0", 32'(vga_gnt), 32'd1);
    vga_q.push_back(pat(va)); va++;
    step();
    stats_clr = 1'b0; vga_addr = 14'(va);
    @(negedge clk);
    check("stall_cleared", stall_cnt, 32'd0);
    check("blk_vga_gnt1", 32'(vga_gnt), 32'd1);
    vga_q.push_back(pat(va)); va++;
    step();
    cyc = 1'b0; stb = 1'b0; vga_req = 1'b0;
    @(negedge clk);
    check("stall_one", stall_cnt, exp_stall_one);
    drain();

    // Reset asserted in the cycle a CPU read is granted.
    cyc = 1'b1; stb = 1'b1; wb_we = 1'b0; wb_adr = 16'h0010; wb_sel = 4'hF;
    @(negedge clk);
    check("rst_mid_grant", 32'(ram_en & ~vga_gnt), 32'd1);
    #1;
    rstn = 1'b0; cyc = 1'b0; stb = 1'b0;
    step();
    @(negedge clk);
    check("rst_mid_no_ack", 32'(wb_ack), 32'd0);
    check("rst_mid_rvalid", 32'(vga_rvalid), 32'd0);
    check("rst_mid_ram_en", 32'(ram_en), 32'd0);
    check("rst_mid_stall", stall_cnt, 32'd0);
    check("rst_mid_run", 32'(dut.run_q), 32'd0);
    step();
    rstn = 1'b1;
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
